// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and defaults for the instruction-fetch front end.
package fetch_unit_pkg;
  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_1000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  typedef enum logic {FROM_PC4 = 1'b0, FROM_EX = 1'b1} pc_src_e;
  typedef enum logic [1:0] {REQ, WAIT, KILL} fetch_state_e;
endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry skid buffer catching a response that lands while decode is stalled.
module fetch_hold_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            drain_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d, pc_q, pc_d;
  always_comb begin
    valid_d = clear_i ? 1'b0 : load_i ? 1'b1 : drain_i ? 1'b0 : valid_q;
    instr_d = load_i ? instr_i : instr_q;
    pc_d    = load_i ? pc_i : pc_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end
  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding-request fetch stage driving the F/D register,
// honouring stall/flush/redirect from the hazard unit.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_F_in,
  input  logic            stall_D_in,
  input  logic            flush_D_in,
  input  pc_src_e         pc_src_in,
  input  logic [XLEN-1:0] pc_target_EX_in,
  output logic            ic_req_valid_out,
  output logic [XLEN-1:0] ic_req_addr_out,
  input  logic            ic_req_ready_in,
  input  logic            ic_resp_valid_in,
  input  logic [XLEN-1:0] ic_resp_data_in,
  output logic [XLEN-1:0] instr_D_out,
  output logic [XLEN-1:0] pc_D_out,
  output logic [XLEN-1:0] pc_plus4_D_out,
  output logic            valid_D_out,
  output logic            fetch_busy_out
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_D_q, instr_D_d, pc_D_q, pc_D_d, pc4_D_q, pc4_D_d;
  logic            valid_D_q, valid_D_d;
  logic            redirect, hs, resp_acc, buf_valid, d_load;
  logic [XLEN-1:0] buf_instr, buf_pc, src_pc;
  assign redirect         = pc_src_in == FROM_EX;
  assign ic_req_valid_out = (state_q == REQ) & ~stall_F_in & ~buf_valid & ~reset;
  assign ic_req_addr_out  = pc_q;
  assign hs               = ic_req_valid_out & ic_req_ready_in;
  assign resp_acc         = (state_q == WAIT) & ic_resp_valid_in & ~redirect;
  assign fetch_busy_out   = (state_q != REQ) | ic_req_valid_out;
  fetch_hold_buf #(.XLEN(XLEN)) u_hold (
    .clk     (clk),
    .reset   (reset),
    .load_i  (resp_acc & stall_D_in),
    .drain_i (buf_valid & ~stall_D_in & ~flush_D_in),
    .clear_i (redirect),
    .instr_i (ic_resp_data_in),
    .pc_i    (pc_q),
    .valid_o (buf_valid),
    .instr_o (buf_instr),
    .pc_o    (buf_pc)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ:     state_d = hs ? (redirect ? KILL : WAIT) : REQ;
      WAIT:    state_d = ic_resp_valid_in ? REQ : redirect ? KILL : WAIT;
      KILL:    state_d = ic_resp_valid_in ? REQ : KILL;
      default: state_d = REQ;
    endcase
    pc_d = redirect ? pc_target_EX_in : resp_acc ? pc_q + XLEN'(4) : pc_q;
  end
  // Buffered instruction is older than any live response, so it wins.
  always_comb begin
    d_load    = buf_valid | resp_acc;
    src_pc    = buf_valid ? buf_pc : pc_q;
    valid_D_d = valid_D_q;
    instr_D_d = instr_D_q;
    pc_D_d    = pc_D_q;
    pc4_D_d   = pc4_D_q;
    if (flush_D_in) begin
      valid_D_d = 1'b0;
      instr_D_d = NOP_INSTR;
    end else if (!stall_D_in) begin
      valid_D_d = d_load;
      instr_D_d = buf_valid ? buf_instr : resp_acc ? ic_resp_data_in : NOP_INSTR;
      pc_D_d    = d_load ? src_pc : pc_D_q;
      pc4_D_d   = d_load ? src_pc + XLEN'(4) : pc4_D_q;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      valid_D_q <= 1'b0;
      instr_D_q <= NOP_INSTR;
      pc_D_q    <= '0;
      pc4_D_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_D_q <= valid_D_d;
      instr_D_q <= instr_D_d;
      pc_D_q    <= pc_D_d;
      pc4_D_q   <= pc4_D_d;
    end
  end
  assign instr_D_out    = instr_D_q;
  assign pc_D_out       = pc_D_q;
  assign pc_plus4_D_out = pc4_D_q;
  assign valid_D_out    = valid_D_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed cycle-by-cycle checks of fetch_unit with a hand-driven cache.
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0;
  logic        reset, stall_F, stall_D, flush_D;
  pc_src_e     pc_src;
  logic [31:0] target, req_addr, resp_data, instr_D, pc_D, pc4_D;
  logic        req_valid, req_ready, resp_valid, valid_D, busy;
  int          n_cmp = 0;
  int          n_bad = 0;
  always #5 clk = ~clk;
  fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .stall_F_in       (stall_F),
    .stall_D_in       (stall_D),
    .flush_D_in       (flush_D),
    .pc_src_in        (pc_src),
    .pc_target_EX_in  (target),
    .ic_req_valid_out (req_valid),
    .ic_req_addr_out  (req_addr),
    .ic_req_ready_in  (req_ready),
    .ic_resp_valid_in (resp_valid),
    .ic_resp_data_in  (resp_data),
    .instr_D_out      (instr_D),
    .pc_D_out         (pc_D),
    .pc_plus4_D_out   (pc4_D),
    .valid_D_out      (valid_D),
    .fetch_busy_out   (busy)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic nxt();
    @(negedge clk);
  endtask
  initial begin
    reset = 1'b1; stall_F = 1'b0; stall_D = 1'b0; flush_D = 1'b0;
    pc_src = FROM_PC4; target = '0; req_ready = 1'b1; resp_valid = 1'b0; resp_data = '0;
    #1;
    chk("rst_req_v", {31'd0, req_valid}, 32'd0);
    chk("rst_valid_D", {31'd0, valid_D}, 32'd0);
    chk("rst_instr", instr_D, NOP);
    chk("rst_pc_D", pc_D, 32'd0);
    chk("rst_pc4_D", pc4_D, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    nxt(); reset = 1'b0; #1;
    chk("req0_v", {31'd0, req_valid}, 32'd1);
    chk("req0_a", req_addr, 32'h1000);
    nxt(); resp_valid = 1'b1; resp_data = 32'hAAAA_1000; #1;
    chk("wait_req_v", {31'd0, req_valid}, 32'd0);
    chk("wait_busy", {31'd0, busy}, 32'd1);
    nxt(); resp_valid = 1'b0; #1;
    chk("d0_valid", {31'd0, valid_D}, 32'd1);
    chk("d0_pc", pc_D, 32'h1000);
    chk("d0_instr", instr_D, 32'hAAAA_1000);
    chk("d0_pc4", pc4_D, 32'h1004);
    chk("req1_a", req_addr, 32'h1004);
    chk("req1_v", {31'd0, req_valid}, 32'd1);
    nxt(); resp_valid = 1'b1; resp_data = 32'hBBBB_1004; #1;
    chk("bubble_valid", {31'd0, valid_D}, 32'd0);
    chk("bubble_instr", instr_D, NOP);
    nxt(); resp_valid = 1'b0; #1;
    chk("d1_pc", pc_D, 32'h1004);
    chk("d1_instr", instr_D, 32'hBBBB_1004);
    chk("req2_a", req_addr, 32'h1008);
    nxt(); resp_valid = 1'b1; resp_data = 32'hCCCC_1008; stall_D = 1'b1; #1;
    nxt(); resp_valid = 1'b0; #1;
    chk("stall1_req_v", {31'd0, req_valid}, 32'd0);
    chk("stall1_valid", {31'd0, valid_D}, 32'd0);
    nxt(); #1;
    chk("stall2_req_v", {31'd0, req_valid}, 32'd0);
    nxt(); stall_D = 1'b0; #1;
    chk("unstall_req_v", {31'd0, req_valid}, 32'd0);
    nxt(); #1;
    chk("buf_valid_D", {31'd0, valid_D}, 32'd1);
    chk("buf_pc_D", pc_D, 32'h1008);
    chk("buf_instr", instr_D, 32'hCCCC_1008);
    chk("buf_pc4", pc4_D, 32'h100C);
    chk("req3_a", req_addr, 32'h100C);
    chk("req3_v", {31'd0, req_valid}, 32'd1);
    nxt(); pc_src = FROM_EX; target = 32'h2000; flush_D = 1'b1; #1;
    chk("redir_req_v", {31'd0, req_valid}, 32'd0);
    nxt(); pc_src = FROM_PC4; flush_D = 1'b0; #1;
    chk("flush_valid", {31'd0, valid_D}, 32'd0);
    chk("flush_instr", instr_D, NOP);
    chk("kill_req_v", {31'd0, req_valid}, 32'd0);
    chk("kill_busy", {31'd0, busy}, 32'd1);
    nxt(); resp_valid = 1'b1; resp_data = 32'hDEAD_100C; #1;
    chk("kill_resp_req_v", {31'd0, req_valid}, 32'd0);
    nxt(); resp_valid = 1'b0; #1;
    chk("stale_instr", instr_D, NOP);
    chk("stale_valid", {31'd0, valid_D}, 32'd0);
    chk("tgt_req_v", {31'd0, req_valid}, 32'd1);
    chk("tgt_req_a", req_addr, 32'h2000);
    pc_src = FROM_EX; target = 32'h3000; #1;
    chk("hs_redir_v", {31'd0, req_valid}, 32'd1);
    chk("hs_redir_a", req_addr, 32'h2000);
    nxt(); pc_src = FROM_PC4; resp_valid = 1'b1; resp_data = 32'hBAD0_2000; #1;
    chk("hs_kill_req_v", {31'd0, req_valid}, 32'd0);
    chk("hs_kill_busy", {31'd0, busy}, 32'd1);
    nxt(); resp_valid = 1'b0; stall_F = 1'b1; #1;
    chk("hs_stale_instr", instr_D, NOP);
    chk("hs_stale_valid", {31'd0, valid_D}, 32'd0);
    chk("stallF_req_v", {31'd0, req_valid}, 32'd0);
    chk("stallF_a", req_addr, 32'h3000);
    nxt(); #1;
    chk("stallF2_a", req_addr, 32'h3000);
    chk("stallF2_req_v", {31'd0, req_valid}, 32'd0);
    chk("stallF2_busy", {31'd0, busy}, 32'd0);
    stall_F = 1'b0; #1;
    chk("unstallF_v", {31'd0, req_valid}, 32'd1);
    chk("unstallF_a", req_addr, 32'h3000);
    nxt(); resp_valid = 1'b1; resp_data = 32'h3333_3000; #1;
    nxt(); resp_valid = 1'b0; #1;
    chk("d3_valid", {31'd0, valid_D}, 32'd1);
    chk("d3_pc", pc_D, 32'h3000);
    chk("req4_a", req_addr, 32'h3004);
    nxt(); reset = 1'b1; #1;
    chk("mid_rst_valid", {31'd0, valid_D}, 32'd0);
    chk("mid_rst_instr", instr_D, NOP);
    chk("mid_rst_pc", pc_D, 32'd0);
    chk("mid_rst_pc4", pc4_D, 32'd0);
    chk("mid_rst_req_v", {31'd0, req_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    nxt(); reset = 1'b0; #1;
    chk("post_rst_v", {31'd0, req_valid}, 32'd1);
    chk("post_rst_a", req_addr, 32'h1000);
    req_ready = 1'b0; pc_src = FROM_EX; target = 32'hFFFF_FFFC; #1;
    nxt(); pc_src = FROM_PC4; req_ready = 1'b1; #1;
    chk("wrap_req_a", req_addr, 32'hFFFF_FFFC);
    chk("wrap_req_v", {31'd0, req_valid}, 32'd1);
    nxt(); resp_valid = 1'b1; resp_data = 32'h7777_7777; #1;
    nxt(); resp_valid = 1'b0; #1;
    chk("wrap_pc_D", pc_D, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4_D, 32'd0);
    chk("wrap_instr", instr_D, 32'h7777_7777);
    chk("wrap_next_a", req_addr, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
